program_memory: RTL and testbench

- Single-port 8-bit byte memory that sits directly downstream of the cpu core's memory bus; it serves instruction and data fetches and data writes.
- It also contains a program loader: a streaming valid/ready byte port that fills memory before execution.
- While a load is in progress it asserts cpu_hold. The top level ORs cpu_hold into the core's reset so the core restarts from ip=0 once loading finishes.

---
 rtl/program_memory_pkg.sv | 16 +
 rtl/program_loader.sv | 86 ++++++++
 rtl/program_memory.sv | 68 ++++++
 tb/tb_program_memory.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/program_memory_pkg.sv
// Shared definitions for the program memory, its loader and the cpu core bus.
package program_memory_pkg;

    localparam int unsigned ADDR_WIDTH = 8;
    localparam int unsigned DATA_WIDTH = 8;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Streaming program loader: accepts valid/ready bytes and emits a write triple,
// holding the cpu off the memory while a load is in progress.
module program_loader
    import program_memory_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = program_memory_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = program_memory_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_length,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic                  load_done,
    output logic                  cpu_hold,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    loader_state_t         state;
    loader_state_t         state_next;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   remain;
    logic                  accept;
    logic                  start_load;

    assign accept     = (state == LOAD) && load_valid;
    assign start_load = (state == IDLE) && load_start && (load_length != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_next = (load_length == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (accept && (remain == (ADDR_WIDTH+1)'(1))) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state == LOAD);
        load_done  = (state == DONE);
        cpu_hold   = (state != IDLE);
    end

    // Lengths beyond the array depth are clamped so a load never laps itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr    <= '0;
            remain <= '0;
        end else if (start_load) begin
            ptr    <= load_base;
            remain <= (load_length > DEPTH) ? DEPTH : load_length;
        end else if (accept) begin
            ptr    <= ptr + ADDR_WIDTH'(1);
            remain <= remain - (ADDR_WIDTH+1)'(1);
        end
    end

    assign wr_en   = accept;
    assign wr_addr = ptr;
    assign wr_data = load_data;

endmodule

// File: rtl/program_memory.sv
// Single-port byte memory on the cpu bus with a built-in program loader that
// owns the array (and holds the cpu) while a load runs.
module program_memory
    import program_memory_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = program_memory_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = program_memory_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memory_operation,
    input  logic [ADDR_WIDTH-1:0] memory_address,
    input  logic [DATA_WIDTH-1:0] to_memory,
    output logic [DATA_WIDTH-1:0] from_memory,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_length,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic                  load_done,
    output logic                  cpu_hold
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    program_loader #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_loader (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_base  (load_base),
        .load_length(load_length),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_done  (load_done),
        .cpu_hold   (cpu_hold),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    // Loader writes only occur while cpu_hold is high, so the two sources never collide.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end else if (!cpu_hold && (memory_operation == MEM_WRITE)) begin
            mem[memory_address] <= to_memory;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            from_memory <= '0;
        end else if (!cpu_hold) begin
            from_memory <= mem[memory_address];
        end
    end

endmodule

// File: tb/tb_program_memory.sv
// Scoreboard bench for program_memory: cpu reads and load_done pulses are
// queued by the stimulus and checked by an independent monitor.
module tb_program_memory;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       memory_operation;
    logic [7:0] memory_address;
    logic [7:0] to_memory;
    logic [7:0] from_memory;
    logic       load_start;
    logic [7:0] load_base;
    logic [8:0] load_length;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       load_done;
    logic       cpu_hold;

    typedef struct {
        string      name;
        logic [7:0] data;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    int         done_q[$];
    logic [8:0] beats[$];
    logic       rd_issue = 1'b0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    program_memory #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8)
    ) dut (
        .clk             (clk),
        .reset           (rst_n),
        .memory_operation(memory_operation),
        .memory_address  (memory_address),
        .to_memory       (to_memory),
        .from_memory     (from_memory),
        .load_start      (load_start),
        .load_base       (load_base),
        .load_length     (load_length),
        .load_valid      (load_valid),
        .load_data       (load_data),
        .load_ready      (load_ready),
        .load_done       (load_done),
        .cpu_hold        (cpu_hold)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: read data is valid the cycle after an issued read; load_done is
    // matched against the cycle predicted when the load was started.
    always @(posedge clk) begin : monitor
        logic    issued;
        rd_exp_t e;
        issued = rd_issue && rst_n;
        #1;
        if (issued) begin
            if (rd_q.size() == 0) begin
                check("rd_queue_underflow", 32'd0, 32'd1);
            end else begin
                e = rd_q.pop_front();
                check(e.name, {24'd0, from_memory}, {24'd0, e.data});
            end
        end
        if (load_done === 1'b1) begin
            if (done_q.size() == 0) begin
                check("unexpected_load_done", 32'd1, 32'd0);
            end else begin
                check("load_done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    task automatic cpu(input logic op, input logic [7:0] a, input logic [7:0] d,
                       input logic rd, input logic [7:0] exp, input string nm);
        @(negedge clk);
        load_start       = 1'b0;
        load_valid       = 1'b0;
        memory_operation = op;
        memory_address   = a;
        to_memory        = d;
        rd_issue         = rd;
        if (rd) rd_q.push_back('{nm, exp});
    endtask

    // Runs one load using the beats queue (bit 8 = valid, bits 7:0 = data).
    // With junk set, the cpu tries to write 0xEE to 0x05 and a second
    // load_start is raised while the first load is still running.
    task automatic run_load(input logic [7:0] base, input logic [8:0] len,
                            input logic junk, input logic [7:0] hold_val);
        int c0;
        int done_cyc;
        int n;
        int cnt;
        @(negedge clk);
        rd_issue         = 1'b0;
        memory_operation = 1'b0;
        memory_address   = 8'h05;
        load_start       = 1'b1;
        load_base        = base;
        load_length      = len;
        load_valid       = 1'b0;
        c0  = cyc;
        n   = (len > 9'd256) ? 256 : int'(len);
        cnt = 0;
        done_cyc = c0 + 1;
        if (n != 0) begin
            for (int i = 0; i < beats.size(); i++) begin
                if (beats[i][8] && cnt < n) begin
                    cnt++;
                    if (cnt == n) done_cyc = c0 + 2 + i;
                end
            end
        end
        done_q.push_back(done_cyc);
        for (int i = 0; i < beats.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("ready_after_start", {31'd0, load_ready}, {31'd0, n != 0});
                check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
            end
            if (junk && i == 1) check("from_memory_held", {24'd0, from_memory}, {24'd0, hold_val});
            load_start  = junk && (i == 1);
            load_base   = 8'h60;
            load_length = 9'd2;
            load_valid  = beats[i][8];
            load_data   = beats[i][7:0];
            if (junk) begin
                memory_operation = 1'b1;
                memory_address   = 8'h05;
                to_memory        = 8'hEE;
            end
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            load_valid       = 1'b0;
            load_start       = 1'b0;
            memory_operation = 1'b0;
            if (cyc == done_cyc) begin
                check("ready_low_in_done", {31'd0, load_ready}, 32'd0);
                check("hold_high_in_done", {31'd0, cpu_hold}, 32'd1);
            end
            if (cyc == done_cyc + 1) begin
                check("hold_released", {31'd0, cpu_hold}, 32'd0);
                break;
            end
            if (k == 7) check("load_timeout", 32'd1, 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n            = 1'b0;
        memory_operation = 1'b0;
        memory_address   = '0;
        to_memory        = '0;
        load_start       = 1'b0;
        load_base        = '0;
        load_length      = '0;
        load_valid       = 1'b0;
        load_data        = '0;
        repeat (3) @(negedge clk);
        check("rst_from_memory", {24'd0, from_memory}, 32'd0);
        check("rst_load_ready", {31'd0, load_ready}, 32'd0);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        rst_n = 1'b1;

        cpu(1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, "");
        cpu(1'b0, 8'h10, 8'h00, 1'b1, 8'hA5, "read_10");
        cpu(1'b1, 8'h20, 8'h11, 1'b0, 8'h00, "");
        cpu(1'b1, 8'h20, 8'h22, 1'b1, 8'h11, "read_first_old");
        cpu(1'b0, 8'h20, 8'h00, 1'b1, 8'h22, "read_after_write");
        cpu(1'b1, 8'h05, 8'h5A, 1'b0, 8'h00, "");
        cpu(1'b0, 8'h05, 8'h00, 1'b1, 8'h5A, "read_05_before_load");

        beats = '{9'h112, 9'h134, 9'h156, 9'h178};
        run_load(8'h00, 9'd4, 1'b1, 8'h5A);
        cpu(1'b0, 8'h00, 8'h00, 1'b1, 8'h12, "load_byte_0");
        cpu(1'b0, 8'h01, 8'h00, 1'b1, 8'h34, "load_byte_1");
        cpu(1'b0, 8'h02, 8'h00, 1'b1, 8'h56, "load_byte_2");
        cpu(1'b0, 8'h03, 8'h00, 1'b1, 8'h78, "load_byte_3");
        cpu(1'b0, 8'h05, 8'h00, 1'b1, 8'h5A, "held_write_ignored");

        beats = '{9'h1AA, 9'h1BB, 9'h0DE, 9'h0AD, 9'h1CC};
        run_load(8'hFE, 9'd3, 1'b0, 8'h00);
        cpu(1'b0, 8'hFE, 8'h00, 1'b1, 8'hAA, "wrap_fe");
        cpu(1'b0, 8'hFF, 8'h00, 1'b1, 8'hBB, "wrap_ff");
        cpu(1'b0, 8'h00, 8'h00, 1'b1, 8'hCC, "wrap_00");
        cpu(1'b0, 8'h01, 8'h00, 1'b1, 8'h34, "wrap_untouched_01");

        cpu(1'b1, 8'h40, 8'h77, 1'b0, 8'h00, "");
        beats = '{9'h199};
        run_load(8'h40, 9'd0, 1'b0, 8'h00);
        cpu(1'b0, 8'h40, 8'h00, 1'b1, 8'h77, "len0_no_write");

        // Reset mid-load after two accepted bytes.
        @(negedge clk);
        rd_issue    = 1'b0;
        load_start  = 1'b1;
        load_base   = 8'h80;
        load_length = 9'd4;
        @(negedge clk);
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'hAB;
        @(negedge clk);
        load_data = 8'hCD;
        @(negedge clk);
        load_valid = 1'b0;
        check("hold_before_abort", {31'd0, cpu_hold}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_load_ready", {31'd0, load_ready}, 32'd0);
        check("abort_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("abort_load_done", {31'd0, load_done}, 32'd0);
        check("abort_from_memory", {24'd0, from_memory}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cpu(1'b0, 8'h80, 8'h00, 1'b1, 8'hAB, "abort_kept_80");
        cpu(1'b0, 8'h81, 8'h00, 1'b1, 8'hCD, "abort_kept_81");
        cpu(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, "");
        repeat (4) @(negedge clk);

        check("rd_queue_drained", rd_q.size(), 32'd0);
        check("done_queue_drained", done_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
